// File: rtl/ram_host_ctrl.sv
// ram_host_ctrl: host-side sequencer for a single-port synchronous RAM.
//
// Accepts one write or read request at a time on a valid/ready handshake and
// drives the RAM pins from registers. Read data comes back on a valid/ready
// response channel and is held until the host takes it. Writes return no
// response.
//
// Optional feature: define WRITE_VERIFY_EN to read back every write and
// compare it with the data written. A mismatch sets the sticky verify_err flag.
// Without the macro, verify_err is tied to 0.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_write          1 = write, 0 = read
//   req_addr/wdata     request address and write data
//   rsp_valid/ready    read response handshake
//   rsp_data           read data, stable while rsp_valid is high
//   ram_data_in        write data to the RAM (registered)
//   ram_address        address to the RAM (registered)
//   ram_write_enable   write strobe to the RAM (registered)
//   ram_data_out       read data from the RAM
//   verify_err         sticky write-verify mismatch flag
module ram_host_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              verify_err
);

`ifdef WRITE_VERIFY_EN
  typedef enum logic [2:0] {
    StIdle, StWr, StRdAddr, StRdWait, StRsp, StVfAddr, StVfWait
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StWr, StRdAddr, StRdWait, StRsp
  } state_e;
`endif

  state_e state_q, state_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic              ram_we_q, ram_we_d;
`ifdef WRITE_VERIFY_EN
  logic              verify_err_q, verify_err_d;
`endif

  // Request fields are captured straight into the RAM pin registers, so the
  // pins already carry the request during the first state after the accept.
  // ram_data_in_q doubles as the reference for write verification.
  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    ram_data_in_d = ram_data_in_q;
    ram_address_d = ram_address_q;
    ram_we_d      = 1'b0;
`ifdef WRITE_VERIFY_EN
    verify_err_d  = verify_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          ram_address_d = req_addr;
          if (req_write) begin
            ram_data_in_d = req_wdata;
            ram_we_d      = 1'b1;
            state_d       = StWr;
          end else begin
            state_d       = StRdAddr;
          end
        end
      end
      StWr: begin
`ifdef WRITE_VERIFY_EN
        state_d = StVfAddr;
`else
        state_d = StIdle;
`endif
      end
      StRdAddr: state_d = StRdWait;
      StRdWait: begin
        rsp_data_d  = ram_data_out;
        rsp_valid_d = 1'b1;
        state_d     = StRsp;
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
`ifdef WRITE_VERIFY_EN
      StVfAddr: state_d = StVfWait;
      StVfWait: begin
        if (ram_data_out != ram_data_in_q) begin
          verify_err_d = 1'b1;
        end
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Registered ready: low through reset, rises on the first edge after release.
    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      ram_data_in_q <= '0;
      ram_address_q <= '0;
      ram_we_q      <= 1'b0;
`ifdef WRITE_VERIFY_EN
      verify_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      ram_data_in_q <= ram_data_in_d;
      ram_address_q <= ram_address_d;
      ram_we_q      <= ram_we_d;
`ifdef WRITE_VERIFY_EN
      verify_err_q  <= verify_err_d;
`endif
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_address      = ram_address_q;
  assign ram_write_enable = ram_we_q;
`ifdef WRITE_VERIFY_EN
  assign verify_err       = verify_err_q;
`else
  assign verify_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ram_host_ctrl.sv
// Testbench for ram_host_ctrl: table of write/read vectors with a scoreboard
// queue for read data, plus hand-written reset, backpressure and verify cases.
module tb_ram_host_ctrl;
  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] ram_data_in;
  logic [AW-1:0] ram_address;
  logic          ram_write_enable;
  logic [DW-1:0] ram_data_out;
  logic          verify_err;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic ve_seen = 1'b0;

  always #5 clk = ~clk;

  ram_host_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .ram_data_in      (ram_data_in),
    .ram_address      (ram_address),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out),
    .verify_err       (verify_err)
  );

  // RAM model: write and address register on the rising edge, data_out is
  // read from the registered address.
  logic [DW-1:0] mem[64];
  logic [AW-1:0] rd_addr_q = '0;
  always @(posedge clk) begin
    if (ram_write_enable) begin
`ifdef WRITE_VERIFY_EN
      if (ram_address == 6'd5 && ram_data_in == 8'h5A) mem[ram_address] <= 8'h00;
      else mem[ram_address] <= ram_data_in;
`else
      mem[ram_address] <= ram_data_in;
`endif
    end
    rd_addr_q <= ram_address;
  end
  assign ram_data_out = mem[rd_addr_q];

  always @(negedge clk) if (verify_err === 1'b1) ve_seen <= 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    check("wr_we_high", {31'd0, ram_write_enable}, 32'd1);
    check("wr_addr", {26'd0, ram_address}, {26'd0, a});
    check("wr_data", {24'd0, ram_data_in}, {24'd0, d});
    @(negedge clk);
    check("wr_we_one_cycle", {31'd0, ram_write_enable}, 32'd0);
  endtask

  // hold > 0 keeps rsp_ready low and presents a competing request meanwhile.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input int hold);
    int lat;
    logic [DW-1:0] got;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    check("rd_busy", {31'd0, req_ready}, 32'd0);
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("rd_latency", lat, 32'd3);
    got = rsp_data;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_addr = a + 6'd1;
      @(negedge clk);
      check("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
      check("bp_data_held", {24'd0, rsp_data}, {24'd0, got});
      check("bp_no_accept", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_q.size() > 0) check("rd_data", {24'd0, got}, {24'd0, exp_q.pop_front()});
    else check("rd_scoreboard_empty", exp_q.size(), 32'd1);
    check("rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    check("ready_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;   // write data, or expected read data
    int            hold;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    vecs[0]  = '{1'b1, 6'd0,  8'h10, 0};
    vecs[1]  = '{1'b1, 6'd2,  8'h11, 0};
    vecs[2]  = '{1'b1, 6'd7,  8'hAF, 0};
    vecs[3]  = '{1'b0, 6'd0,  8'h10, 0};
    vecs[4]  = '{1'b0, 6'd2,  8'h11, 5};
    vecs[5]  = '{1'b0, 6'd7,  8'hAF, 0};
    vecs[6]  = '{1'b1, 6'd63, 8'hFF, 0};
    vecs[7]  = '{1'b0, 6'd63, 8'hFF, 0};
    vecs[8]  = '{1'b1, 6'd0,  8'h01, 0};
    vecs[9]  = '{1'b0, 6'd63, 8'hFF, 0};
    vecs[10] = '{1'b0, 6'd0,  8'h01, 0};
    vecs[11] = '{1'b1, 6'd1,  8'hC3, 0};
    vecs[12] = '{1'b0, 6'd1,  8'hC3, 2};
    vecs[13] = '{1'b0, 6'd2,  8'h11, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_we", {31'd0, ram_write_enable}, 32'd0);
    check("rst_addr", {26'd0, ram_address}, 32'd0);
    check("rst_din", {24'd0, ram_data_in}, 32'd0);
    check("rst_verify_err", {31'd0, verify_err}, 32'd0);
    rst_n = 1'b1;
    check("release_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("release_ready_next", {31'd0, req_ready}, 32'd1);

    // Vector table
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else do_read(vecs[i].addr, vecs[i].data, vecs[i].hold);
    end

    // Write throughput: back-to-back writes accepted every 2 cycles
    begin
      int gap = 0;
      do_write(6'd20, 8'h20);
      // do_write returned one cycle after WR; ready must already be back
      while (req_ready !== 1'b1 && gap < 10) begin @(negedge clk); gap++; end
`ifdef WRITE_VERIFY_EN
      check("wr_cost", gap, 32'd2);
`else
      check("wr_cost", gap, 32'd0);
`endif
    end

    // Reset during WR: write enable drops without waiting for an edge
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd9; req_wdata = 8'h77;
    @(posedge clk);
    #1;
    check("wr_pre_rst_we", {31'd0, ram_write_enable}, 32'd1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("wr_rst_we_async", {31'd0, ram_write_enable}, 32'd0);
    check("wr_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("wr_rst_ready_next", {31'd0, req_ready}, 32'd1);
    do_read(6'd9, 8'h00, 0);  // aborted write is not retried

    // Reset during RSP: pending response discarded
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd0;
    exp_q.push_back(8'h01);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rsp_pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rsp_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rsp_rst_data", {24'd0, rsp_data}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rsp_rst_ready_next", {31'd0, req_ready}, 32'd1);
    do_read(6'd63, 8'hFF, 0);

    // Write verify
`ifdef WRITE_VERIFY_EN
    do_write(6'd3, 8'h33);
    repeat (2) @(negedge clk);
    check("vf_good_clear", {31'd0, verify_err}, 32'd0);
    do_write(6'd5, 8'h5A);
    repeat (2) @(negedge clk);
    check("vf_bad_set", {31'd0, verify_err}, 32'd1);
    do_write(6'd4, 8'h44);
    repeat (2) @(negedge clk);
    check("vf_sticky", {31'd0, verify_err}, 32'd1);
`else
    do_write(6'd5, 8'h5A);
    repeat (2) @(negedge clk);
    check("no_vf_ever", {31'd0, ve_seen}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
